// File: rtl/pmod_cls_text_streamer.sv
// Pmod CLS text streamer: coalesces clear/line requests into pending flags and
// emits CLS escape-sequence frames one byte at a time over a valid/ready link.
module pmod_cls_text_streamer #(
  parameter int parm_lines          = 2,
  parameter int parm_cols           = 16,
  parameter int parm_refresh_cycles = 0
) (
  input  logic                              i_clk_40mhz,
  input  logic                              i_rst_40mhz,
  input  logic                              i_ce_mhz,
  input  logic                              i_req_clear,
  input  logic [parm_lines-1:0]             i_req_line,
  input  logic [parm_lines*parm_cols*8-1:0] i_dat_lines,
  output logic                              o_tx_valid,
  output logic [7:0]                        o_tx_byte,
  output logic                              o_tx_last,
  input  logic                              i_tx_ready,
  output logic                              o_busy,
  output logic [parm_lines-1:0]             o_pending
);

  localparam int IW = $clog2((parm_cols > 6) ? parm_cols : 6);
  localparam int LW = (parm_lines > 1) ? $clog2(parm_lines) : 1;
  localparam int RW = (parm_refresh_cycles > 1) ? $clog2(parm_refresh_cycles) : 1;
  localparam logic [RW-1:0] RELOAD   = (parm_refresh_cycles > 0) ? RW'(parm_refresh_cycles - 1) : '0;
  localparam logic [IW-1:0] LAST_COL = IW'(parm_cols - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_HDR, S_TXT} state_t;

  state_t                 r_state;
  logic [IW-1:0]          r_idx;
  logic                   r_clr_pend;
  logic [parm_lines-1:0]  r_dirty;
  logic [RW-1:0]          r_refresh_cnt;
  logic [7:0]             r_row;
  logic [7:0]             r_snap [parm_cols];

  logic                   w_accept;
  logic [IW-1:0]          w_next_idx;
  logic                   w_refresh_tick;
  logic                   w_take_clr;
  logic                   w_take_line;
  logic                   w_sel_hit;
  logic [LW-1:0]          w_sel_idx;
  logic [parm_lines-1:0]  w_sel_onehot;
  logic [parm_cols*8-1:0] w_line;

  assign w_accept       = o_tx_valid & i_tx_ready;
  assign w_next_idx     = r_idx + 1'b1;
  assign w_refresh_tick = (parm_refresh_cycles > 0) && i_ce_mhz && (r_refresh_cnt == '0);
  assign w_take_clr     = (r_state == S_IDLE) && r_clr_pend;
  assign w_take_line    = (r_state == S_IDLE) && !r_clr_pend && w_sel_hit;

  assign o_busy    = (r_state != S_IDLE) | r_clr_pend | (|r_dirty);
  assign o_pending = r_dirty;

  // Lowest dirty line wins; its text is muxed out for the snapshot.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    w_sel_hit    = 1'b0;
    w_sel_idx    = '0;
    w_sel_onehot = '0;
    for (int n = parm_lines - 1; n >= 0; n--) begin
      if (r_dirty[n]) begin
        w_sel_hit    = 1'b1;
        w_sel_idx    = LW'(n);
        w_sel_onehot = '0;
        w_sel_onehot[n] = 1'b1;
      end
    end
    w_line = '0;
    for (int n = 0; n < parm_lines; n++) begin
      if (w_sel_idx == LW'(n)) w_line = i_dat_lines[n*parm_cols*8 +: parm_cols*8];
    end
  end

  function automatic logic [7:0] clr_byte(input logic [IW-1:0] idx);
    case (idx)
      IW'(0):  clr_byte = 8'h1B;
      IW'(1):  clr_byte = 8'h5B;
      default: clr_byte = 8'h6A;
    endcase
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [IW-1:0] idx, input logic [7:0] row);
    case (idx)
      IW'(0):  hdr_byte = 8'h1B;
      IW'(1):  hdr_byte = 8'h5B;
      IW'(2):  hdr_byte = row;
      IW'(3):  hdr_byte = 8'h3B;
      IW'(4):  hdr_byte = 8'h30;
      default: hdr_byte = 8'h48;
    endcase
  endfunction

  always_ff @(posedge i_clk_40mhz) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst_40mhz) begin
      r_refresh_cnt <= RELOAD;
    end else if ((parm_refresh_cycles > 0) && i_ce_mhz) begin
      r_refresh_cnt <= (r_refresh_cnt == '0) ? RELOAD : r_refresh_cnt - 1'b1;
    end
  end

  // Set terms are OR-ed after the clear so a same-cycle request survives selection.
  always_ff @(posedge i_clk_40mhz) begin
    if (i_rst_40mhz) begin
      r_clr_pend <= 1'b0;
      r_dirty    <= '0;
    end else begin
      r_clr_pend <= (r_clr_pend & ~w_take_clr) | i_req_clear;
      r_dirty    <= (r_dirty & ~(w_take_line ? w_sel_onehot : '0))
                  | i_req_line | {parm_lines{w_refresh_tick}};
    end
  end

  // NOTE: the snapshot buffer is a plain datapath memory and is deliberately not reset.
  always_ff @(posedge i_clk_40mhz) begin
    if (w_take_line) begin
      r_row <= 8'h30 + 8'(w_sel_idx);
      for (int c = 0; c < parm_cols; c++) r_snap[c] <= w_line[c*8 +: 8];
    end
  end

  always_ff @(posedge i_clk_40mhz) begin
    if (i_rst_40mhz) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      o_tx_valid <= 1'b0;
      o_tx_byte  <= 8'h00;
      o_tx_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_clr_pend || w_sel_hit) begin
            r_state    <= r_clr_pend ? S_CLR : S_HDR;
            r_idx      <= '0;
            o_tx_valid <= 1'b1;
            o_tx_byte  <= 8'h1B;
            o_tx_last  <= 1'b0;
          end
        end
        S_CLR: begin
          if (w_accept) begin
            if (r_idx == IW'(2)) begin
              r_state    <= S_IDLE;
              o_tx_valid <= 1'b0;
              o_tx_last  <= 1'b0;
            end else begin
              r_idx     <= w_next_idx;
              o_tx_byte <= clr_byte(w_next_idx);
              o_tx_last <= (w_next_idx == IW'(2));
            end
          end
        end
        S_HDR: begin
          if (w_accept) begin
            if (r_idx == IW'(5)) begin
              r_state   <= S_TXT;
              r_idx     <= '0;
              o_tx_byte <= r_snap[0];
              o_tx_last <= (parm_cols == 1);
            end else begin
              r_idx     <= w_next_idx;
              o_tx_byte <= hdr_byte(w_next_idx, r_row);
            end
          end
        end
        S_TXT: begin
          if (w_accept) begin
            if (r_idx == LAST_COL) begin
              r_state    <= S_IDLE;
              o_tx_valid <= 1'b0;
              o_tx_last  <= 1'b0;
            end else begin
              r_idx     <= w_next_idx;
              o_tx_byte <= r_snap[w_next_idx];
              o_tx_last <= (w_next_idx == LAST_COL);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
